// File: rtl/stopwatch_ctrl.sv
// Mode/sequencing controller for the MM:SS stopwatch datapath: turns buttons, switches and tick
// strobes into clear/step strobes, count direction and a blink mask. Optional lap: STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned ADJ_DIV   = 1,
  parameter int unsigned BLINK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_btn,
  input  logic       clr_btn,
  input  logic       sw_sel,
  input  logic       sw_adj,
  input  logic       sw_dn,
  input  logic       at_zero,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_btn,
  output logic       lap_hold,
`endif
  output logic       cnt_clr,
  output logic       sec_step,
  output logic       min_step,
  output logic       cnt_dn,
  output logic [3:0] blank_an,
  output logic       run_led,
  output logic [1:0] state_o
);

  localparam logic [1:0] CLEAR  = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] PAUSE  = 2'b10;
  localparam logic [1:0] ADJUST = 2'b11;

  localparam logic [3:0] ADJ_LAST   = 4'(ADJ_DIV - 1);
  localparam logic [3:0] BLINK_LAST = 4'(BLINK_DIV - 1);

  logic [1:0] state, state_n;
  logic       pause_prev, clr_prev, sel_prev;
  logic       pause_rise, clr_rise;
  logic       phase, phase_n;
  logic [3:0] adj_cnt, adj_cnt_n;
  logic [3:0] blink_cnt, blink_cnt_n;
  logic       clr_n, sec_n, min_n, dn_n, run_n;
  logic [3:0] blank_n;

`ifdef STOPWATCH_LAP_EN
  logic lap_prev, lap_rise, lap_n;
  assign lap_rise = lap_btn & ~lap_prev;
`endif

  assign pause_rise = pause_btn & ~pause_prev;
  assign clr_rise   = clr_btn & ~clr_prev;
  assign state_o    = state;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned
    // and infer a latch.
    state_n     = state;
    clr_n       = 1'b0;
    sec_n       = 1'b0;
    min_n       = 1'b0;
    dn_n        = 1'b0;
    blank_n     = 4'b0000;
    phase_n     = phase;
    adj_cnt_n   = adj_cnt;
    blink_cnt_n = blink_cnt;

    if (clr_rise) begin
      state_n = CLEAR;
    end else begin
      case (state)
        CLEAR: begin
          state_n = PAUSE;
          clr_n   = 1'b1;
        end
        PAUSE: begin
          if (sw_adj)          state_n = ADJUST;
          else if (pause_rise) state_n = RUN;
        end
        RUN: begin
          if (sw_adj)          state_n = ADJUST;
          else if (pause_rise) state_n = PAUSE;
          else if (tick_1hz) begin
            // Counting down stops at 00:00 instead of wrapping.
            if (sw_dn && at_zero) state_n = PAUSE;
            else                  sec_n   = 1'b1;
          end
        end
        ADJUST: begin
          if (!sw_adj) begin
            state_n = PAUSE;
          end else begin
            if (sw_sel != sel_prev) begin
              adj_cnt_n = 4'd0;
            end else if (tick_2hz) begin
              if (adj_cnt == ADJ_LAST) begin
                adj_cnt_n = 4'd0;
                if (sw_sel) min_n = 1'b1;
                else        sec_n = 1'b1;
              end else begin
                adj_cnt_n = adj_cnt + 4'd1;
              end
            end
            if (tick_2hz) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = 4'd0;
                phase_n     = ~phase;
              end else begin
                blink_cnt_n = blink_cnt + 4'd1;
              end
            end
            // The pair being stepped stays lit in the step cycle so the new value is visible.
            if (phase_n && !(sec_n || min_n))
              blank_n = sw_sel ? 4'b1100 : 4'b0011;
          end
        end
        default: state_n = CLEAR;
      endcase
    end

    if (state_n != ADJUST) begin
      adj_cnt_n   = 4'd0;
      blink_cnt_n = 4'd0;
      phase_n     = 1'b0;
      blank_n     = 4'b0000;
    end
    if (state_n == RUN) dn_n = sw_dn;
    run_n = (state_n == RUN);

`ifdef STOPWATCH_LAP_EN
    lap_n = lap_hold;
    if (state_n != RUN)                  lap_n = 1'b0;
    else if (state == RUN && lap_rise)   lap_n = ~lap_hold;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      pause_prev <= 1'b0;
      clr_prev   <= 1'b0;
      sel_prev   <= 1'b0;
      phase      <= 1'b0;
      adj_cnt    <= 4'd0;
      blink_cnt  <= 4'd0;
      cnt_clr    <= 1'b0;
      sec_step   <= 1'b0;
      min_step   <= 1'b0;
      cnt_dn     <= 1'b0;
      blank_an   <= 4'b0000;
      run_led    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_prev   <= 1'b0;
      lap_hold   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values,
      // independent of statement order.
      state      <= state_n;
      pause_prev <= pause_btn;
      clr_prev   <= clr_btn;
      sel_prev   <= sw_sel;
      phase      <= phase_n;
      adj_cnt    <= adj_cnt_n;
      blink_cnt  <= blink_cnt_n;
      cnt_clr    <= clr_n;
      sec_step   <= sec_n;
      min_step   <= min_n;
      cnt_dn     <= dn_n;
      blank_an   <= blank_n;
      run_led    <= run_n;
`ifdef STOPWATCH_LAP_EN
      lap_prev   <= lap_btn;
      lap_hold   <= lap_n;
`endif
    end
  end

  a_step_exclusive: assert property (@(posedge clk) disable iff (rst) !(sec_step && min_step));
  a_no_step_on_clr: assert property (@(posedge clk) disable iff (rst)
                                     !(cnt_clr && (sec_step || min_step)));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (ADJ_DIV=2, BLINK_DIV=1): expectations are queued as each
// cycle's stimulus is applied and compared against the registered outputs just after the edge.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_CLR = 2'b00;
  localparam logic [1:0] S_RUN = 2'b01;
  localparam logic [1:0] S_PAU = 2'b10;
  localparam logic [1:0] S_ADJ = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic       pause_btn = 1'b0, clr_btn = 1'b0;
  logic       sw_sel = 1'b0, sw_adj = 1'b0, sw_dn = 1'b0, at_zero = 1'b0;
  logic       cnt_clr, sec_step, min_step, cnt_dn, run_led;
  logic [3:0] blank_an;
  logic [1:0] state_o;
`ifdef STOPWATCH_LAP_EN
  logic       lap_btn = 1'b0;
  logic       lap_hold;
`endif

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       clr, sec, min, dn;
    logic [3:0] blk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  stopwatch_ctrl #(.ADJ_DIV(2), .BLINK_DIV(1)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause_btn(pause_btn), .clr_btn(clr_btn), .sw_sel(sw_sel), .sw_adj(sw_adj),
    .sw_dn(sw_dn), .at_zero(at_zero),
`ifdef STOPWATCH_LAP_EN
    .lap_btn(lap_btn), .lap_hold(lap_hold),
`endif
    .cnt_clr(cnt_clr), .sec_step(sec_step), .min_step(min_step), .cnt_dn(cnt_dn),
    .blank_an(blank_an), .run_led(run_led), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic clr,
                            input logic sec, input logic min, input logic dn,
                            input logic [3:0] blk);
    exp_t e;
    e.tag = tag; e.st = st; e.clr = clr; e.sec = sec; e.min = min; e.dn = dn; e.blk = blk;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".state"},    {2'b00, state_o}, {2'b00, e.st});
    check({e.tag, ".cnt_clr"},  {3'b000, cnt_clr},  {3'b000, e.clr});
    check({e.tag, ".sec_step"}, {3'b000, sec_step}, {3'b000, e.sec});
    check({e.tag, ".min_step"}, {3'b000, min_step}, {3'b000, e.min});
    check({e.tag, ".cnt_dn"},   {3'b000, cnt_dn},   {3'b000, e.dn});
    check({e.tag, ".blank_an"}, blank_an, e.blk);
    check({e.tag, ".run_led"},  {3'b000, run_led},  {3'b000, (e.st == S_RUN)});
  endtask

  // Apply current inputs across one clock edge and compare what the DUT registered.
  task automatic step(input string tag, input logic [1:0] st, input logic clr, input logic sec,
                      input logic min, input logic dn, input logic [3:0] blk);
    expect_out(tag, st, clr, sec, min, dn, blk);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and the single clear pulse after release.
    step("reset_hold", S_CLR, 0, 0, 0, 0, 4'h0);
    rst = 1'b0;
    step("clr_pulse",  S_PAU, 1, 0, 0, 0, 4'h0);
    step("clr_done",   S_PAU, 0, 0, 0, 0, 4'h0);

    // Start counting; three seconds ticks, each step one cycle after its tick.
    pause_btn = 1'b1;
    step("start_run", S_RUN, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1'b1;
      step($sformatf("run_tick%0d", i), S_RUN, 0, 1, 0, 0, 4'h0);
      tick_1hz = 1'b0;
      step($sformatf("run_idle%0d", i), S_RUN, 0, 0, 0, 0, 4'h0);
    end

    // Count down, then stop at zero instead of underflowing.
    sw_dn = 1'b1;
    step("dn_sel",     S_RUN, 0, 0, 0, 1, 4'h0);
    tick_1hz = 1'b1;
    step("dn_tick",    S_RUN, 0, 1, 0, 1, 4'h0);
    tick_1hz = 1'b0;
    step("dn_idle",    S_RUN, 0, 0, 0, 1, 4'h0);
    tick_1hz = 1'b1; at_zero = 1'b1;
    step("dn_zero",    S_PAU, 0, 0, 0, 0, 4'h0);
    tick_1hz = 1'b0; at_zero = 1'b0; sw_dn = 1'b0;

    // Adjust minutes: four 2 Hz ticks give two minute steps; cnt_dn held low despite sw_dn.
    sw_sel = 1'b1;
    step("adj_presel", S_PAU, 0, 0, 0, 0, 4'h0);
    sw_adj = 1'b1; sw_dn = 1'b1;
    step("adj_enter",  S_ADJ, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick_2hz = 1'b1;
      step($sformatf("adj_tick%0d", i), S_ADJ, 0, 0, (i % 2 == 1), 0,
           (i % 2 == 1) ? 4'b0000 : 4'b1100);
      tick_2hz = 1'b0;
      step($sformatf("adj_idle%0d", i), S_ADJ, 0, 0, 0, 0,
           (i % 2 == 1) ? 4'b0000 : 4'b1100);
    end

    // Select change restarts the divider; the stepped pair is unblanked in its step cycle.
    tick_2hz = 1'b1;
    step("sel_tickA",  S_ADJ, 0, 0, 0, 0, 4'b1100);
    tick_2hz = 1'b0; sw_sel = 1'b0;
    step("sel_change", S_ADJ, 0, 0, 0, 0, 4'b0011);
    tick_2hz = 1'b1;
    step("sel_tickC",  S_ADJ, 0, 0, 0, 0, 4'b0000);
    step("sel_tickD",  S_ADJ, 0, 1, 0, 0, 4'b0000);
    tick_2hz = 1'b0;
    step("sel_idle",   S_ADJ, 0, 0, 0, 0, 4'b0011);
    sw_adj = 1'b0; sw_dn = 1'b0;
    step("adj_exit",   S_PAU, 0, 0, 0, 0, 4'h0);

    // Adjust request wins over a simultaneous pause press.
    pause_btn = 1'b1; sw_adj = 1'b1;
    step("adj_over_pause", S_ADJ, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b0; sw_adj = 1'b0;
    step("adj_over_exit",  S_PAU, 0, 0, 0, 0, 4'h0);

    // Clear beats pause and tick in RUN.
    pause_btn = 1'b1;
    step("clr_run",    S_RUN, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b0;
    step("clr_run2",   S_RUN, 0, 0, 0, 0, 4'h0);
    clr_btn = 1'b1; pause_btn = 1'b1; tick_1hz = 1'b1;
    step("clr_prio",   S_CLR, 0, 0, 0, 0, 4'h0);
    clr_btn = 1'b0; pause_btn = 1'b0; tick_1hz = 1'b0;
    step("clr_prio_pulse", S_PAU, 1, 0, 0, 0, 4'h0);
    step("clr_prio_done",  S_PAU, 0, 0, 0, 0, 4'h0);

    // Pause held for 1000 cycles toggles exactly once.
    pause_btn = 1'b1;
    step("hold_start", S_RUN, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 1000; i++) step("hold", S_RUN, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b0;
    step("hold_release", S_RUN, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b1;
    step("hold_pause",   S_PAU, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b0;

    // Asynchronous reset mid-run drops the pending step.
    step("mid_pre",    S_PAU, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b1;
    step("mid_run",    S_RUN, 0, 0, 0, 0, 4'h0);
    pause_btn = 1'b0; tick_1hz = 1'b1;
    #3 rst = 1'b1;
    #1;
    expect_out("mid_rst", S_CLR, 0, 0, 0, 0, 4'h0);
    compare_out();
    @(posedge clk);
    #1;
    expect_out("mid_rst_edge", S_CLR, 0, 0, 0, 0, 4'h0);
    compare_out();
    tick_1hz = 1'b0; rst = 1'b0;
    step("mid_release", S_PAU, 1, 0, 0, 0, 4'h0);
    step("mid_done",    S_PAU, 0, 0, 0, 0, 4'h0);

    check("scoreboard_empty", 4'(sb.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode/sequencing controller for the stopwatch counter datapath (MM:SS BCD counters plus 7-seg scan). Converts debounced buttons, mode switches and divided-clock tick strobes into single-cycle clear/step strobes, a count direction and a per-digit blink mask. Everything runs on the system clock; counters are clock-enabled by this block's strobes, never clocked by divided clocks.

Parameters:
ADJ_DIV, 1, number of tick_2hz strobes per adjust step (1..15)
BLINK_DIV, 1, number of tick_2hz strobes per blink phase toggle (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick_1hz  in  1  one-cycle strobe, 1 Hz
tick_2hz  in  1  one-cycle strobe, 2 Hz
pause_btn  in  1  debounced pause button level
clr_btn  in  1  debounced clear button level (synchronous clear; distinct from rst)
sw_sel  in  1  adjust target: 0 = seconds, 1 = minutes
sw_adj  in  1  adjust mode request
sw_dn  in  1  count-down select
at_zero  in  1  datapath reports all four digits = 0
cnt_clr  out  1  one-cycle strobe: load counters with 00:00
sec_step  out  1  one-cycle strobe: step seconds (datapath carries into minutes)
min_step  out  1  one-cycle strobe: step minutes only, no carry
cnt_dn  out  1  direction for steps: 1 = decrement
blank_an  out  4  per-digit blank mask; [1:0] seconds, [3:2] minutes
run_led  out  1  1 while in RUN
state_o  out  2  current state encoding

Behaviour:
- Reset is asynchronous, active-high, on rst; all outputs are registered.
- Reset values: state = CLEAR, cnt_clr=0, sec_step=0, min_step=0, cnt_dn=0, blank_an=4'b0000, run_led=0, blink phase=0, divider counters=0, button history=0.
- Edge detect: pause_btn/clr_btn are registered once; rise = level & ~prev. Holding a button gives exactly one event.
- States: CLEAR=00, RUN=01, PAUSE=10, ADJUST=11.
- CLEAR: cnt_clr=1 for exactly one cycle, then -> PAUSE unconditionally.
- Priority per cycle: clr rise > sw_adj > pause rise > tick events.
- Any state, clr rise -> CLEAR; ADJUST divider and blink phase cleared.
- RUN or PAUSE with sw_adj=1 -> ADJUST; a pause rise in the same cycle is discarded.
- PAUSE, pause rise, sw_adj=0 -> RUN. RUN, pause rise -> PAUSE.
- RUN: each tick_1hz -> sec_step=1 on the next cycle (1-cycle latency); cnt_dn = sw_dn, sampled every cycle.
- RUN, sw_dn=1, at_zero=1 on tick_1hz: no step; -> PAUSE (no underflow past 00:00). With sw_dn=0 the datapath wraps 59:59 -> 00:00 itself.
- ADJUST: cnt_dn forced 0. Every ADJ_DIV-th tick_2hz -> sec_step (sw_sel=0) or min_step (sw_sel=1), 1-cycle latency. sw_sel changes take effect immediately and restart the divider.
- ADJUST blink: phase toggles every BLINK_DIV-th tick_2hz. phase=1 blanks the selected pair (4'b0011 sec, 4'b1100 min); pair is forced unblanked in the cycle its step strobe is high.
- ADJUST with sw_adj=0 -> PAUSE; blank_an=0, phase=0.
- sec_step and min_step are never high in the same cycle; no step is issued in a cycle where cnt_clr=1.
- Ticks in PAUSE or CLEAR are ignored.
- rst mid-operation: immediate return to reset values; the pending strobe is dropped.

Optional Feature:
STOPWATCH_LAP_EN: adds input lap_btn (1) and output lap_hold (1, reset 0). In RUN, a lap_btn rise toggles lap_hold; display latching is done downstream while counting continues. lap_hold is cleared on leaving RUN and on clr rise. Without the macro, neither port exists and the lap logic is absent.

Test Plan:
- rst pulse, then release -> cnt_clr high exactly one cycle, state_o=10, all other outputs 0.
- pause rise, then 3 tick_1hz -> state_o=01, run_led=1, exactly 3 sec_step pulses, each one cycle after its tick.
- sw_dn=1 in RUN, at_zero=1 with tick_1hz -> no sec_step, state_o=10 next cycle.
- sw_adj=1, sw_sel=1, ADJ_DIV=2, 4 tick_2hz -> 2 min_step pulses, 0 sec_step, blank_an alternates 1100/0000, cnt_dn=0.
- clr rise together with pause rise and tick_1hz in RUN -> cnt_clr=1, no sec_step, state_o=10 after CLEAR.
- pause_btn held high for 1000 cycles -> exactly one RUN/PAUSE transition.
